// File: rtl/twiddle_gen.sv
// Twiddle-factor generator for a radix-2^2 SDF FFT stage: tracks the sample index,
// derives the exponent e = m*k mod N and looks up cos/-sin from an elaboration-time table.
module twiddle_gen #(
  parameter int WIDTH = 16,
  parameter int LOG2N = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic                    in_sync,
  output logic signed [WIDTH-1:0] tw_re,
  output logic signed [WIDTH-1:0] tw_im,
  output logic                    tw_valid,
  output logic [LOG2N-1:0]        tw_idx
);

  localparam int  N  = 1 << LOG2N;
  localparam int  QN = N / 4;
  localparam real PI = 3.14159265358979323846;

  function automatic real sin_poly(input real a);
    real t;
    real s;
    t = a;
    s = a;
    for (int k = 1; k < 20; k++) begin
      t = -t * a * a / ((2.0 * k) * (2.0 * k + 1.0));
      s = s + t;
    end
    return s;
  endfunction

  function automatic real cos_poly(input real a);
    real t;
    real s;
    t = 1.0;
    s = 1.0;
    for (int k = 1; k < 20; k++) begin
      t = -t * a * a / ((2.0 * k - 1.0) * (2.0 * k));
      s = s + t;
    end
    return s;
  endfunction

  // Round half away from zero, then clip +1.0 to the largest positive code.
  function automatic logic signed [WIDTH-1:0] round_sat(input real x);
    real    v;
    longint r;
    longint maxv;
    v    = x * real'(longint'(1) << (WIDTH - 1));
    maxv = (longint'(1) << (WIDTH - 1)) - 1;
    if (v >= 0.0) r = longint'($rtoi(v + 0.5));
    else          r = -longint'($rtoi(-v + 0.5));
    if (r > maxv) r = maxv;
    return r[WIDTH-1:0];
  endfunction

  // Quadrant folding keeps the polynomial in [0, pi/2) and makes axis points exact.
  function automatic logic [N*WIDTH-1:0] build_table(input logic want_im);
    logic [N*WIDTH-1:0] tab;
    real a;
    real c;
    real s;
    real cr;
    real si;
    tab = '0;
    for (int e = 0; e < N; e++) begin
      a = 2.0 * PI * real'(e % QN) / real'(N);
      c = cos_poly(a);
      s = sin_poly(a);
      case (e / QN)
        0:       begin cr = c;  si = s;  end
        1:       begin cr = -s; si = c;  end
        2:       begin cr = -c; si = -s; end
        default: begin cr = s;  si = -c; end
      endcase
      tab[e*WIDTH +: WIDTH] = want_im ? round_sat(-si) : round_sat(cr);
    end
    return tab;
  endfunction

  localparam logic [N*WIDTH-1:0] TAB_RE = build_table(1'b0);
  localparam logic [N*WIDTH-1:0] TAB_IM = build_table(1'b1);

  logic [LOG2N-1:0] n;
  logic [LOG2N-1:0] idx;
  logic [LOG2N-1:0] e_next;
  logic [LOG2N-1:0] e_p1;
  logic             vld_p1;

  assign idx = (in_valid && in_sync) ? '0 : n;

  // k is the bit-reversed quarter number; truncating the product gives mod N.
  if (LOG2N > 2) begin : g_exp
    logic [1:0]       q;
    logic [LOG2N-1:0] m;
    logic [LOG2N-1:0] k;
    assign q      = idx[LOG2N-1 -: 2];
    assign m      = {2'b00, idx[LOG2N-3:0]};
    assign k      = {{(LOG2N-2){1'b0}}, q[0], q[1]};
    assign e_next = m * k;
  end else begin : g_exp0
    assign e_next = '0;
  end

  // Stage 1: sample counter, exponent and valid
  always_ff @(posedge clk) begin
    if (rst) begin
      n      <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) n <= idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    e_p1 <= e_next;
  end

  // Stage 2: table lookup into the held output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tw_valid <= 1'b0;
      tw_re    <= '0;
      tw_im    <= '0;
      tw_idx   <= '0;
    end else begin
      tw_valid <= vld_p1;
      if (vld_p1) begin
        tw_re  <= TAB_RE[int'(e_p1)*WIDTH +: WIDTH];
        tw_im  <= TAB_IM[int'(e_p1)*WIDTH +: WIDTH];
        tw_idx <= e_p1;
      end
    end
  end

endmodule

// File: tb/tb_twiddle_gen.sv
// Scoreboard bench for twiddle_gen (WIDTH=16, LOG2N=4): a reference index/exponent model
// queues expected twiddles at the input edge; outputs are compared one cycle-pair later.
module tb_twiddle_gen;
  localparam int WIDTH = 16;
  localparam int LOG2N = 4;
  localparam int N     = 16;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic                    in_sync;
  logic signed [WIDTH-1:0] tw_re;
  logic signed [WIDTH-1:0] tw_im;
  logic                    tw_valid;
  logic [LOG2N-1:0]        tw_idx;

  twiddle_gen #(.WIDTH(WIDTH), .LOG2N(LOG2N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sync(in_sync),
    .tw_re(tw_re), .tw_im(tw_im), .tw_valid(tw_valid), .tw_idx(tw_idx)
  );

  always #5 clk = ~clk;

  typedef struct { int e; int re; int im; } exp_t;

  exp_t       sb[$];
  exp_t       last;
  exp_t       cur;
  int         m_n;
  logic [1:0] exp_v;
  int         checks;
  int         passes;

  function automatic int ref_exp(input int index);
    int ktab[4];
    ktab = '{0, 2, 1, 3};
    return ((index % (N / 4)) * ktab[index / (N / 4)]) % N;
  endfunction

  function automatic int ref_val(input int e, input bit im);
    real a;
    real x;
    real r;
    a = 2.0 * 3.14159265358979323846 * real'(e) / real'(N);
    x = (im ? -$sin(a) : $cos(a)) * 32768.0;
    r = (x >= 0.0) ? $floor(x + 0.5) : -$floor(-x + 0.5);
    if (r > 32767.0) r = 32767.0;
    return int'(r);
  endfunction

  // One rising edge with the current inputs; the reference model advances alongside.
  task automatic tick();
    int index;
    int e;
    @(posedge clk);
    if (rst) begin
      m_n   = 0;
      exp_v = 2'b00;
      sb.delete();
      last  = '{0, 0, 0};
    end else begin
      exp_v = {exp_v[0], in_valid};
      if (in_valid) begin
        index = in_sync ? 0 : m_n;
        m_n   = (index + 1) % N;
        e     = ref_exp(index);
        sb.push_back('{e, ref_val(e, 1'b0), ref_val(e, 1'b1)});
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_sync = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    checks++; if (tw_valid !== 1'b0) $display("FAIL reset tw_valid: got %b want 0", tw_valid); else passes++;
    checks++; if (tw_re !== 16'sd0) $display("FAIL reset tw_re: got %0d want 0", tw_re); else passes++;
    checks++; if (tw_im !== 16'sd0) $display("FAIL reset tw_im: got %0d want 0", tw_im); else passes++;
    checks++; if (tw_idx !== 4'd0) $display("FAIL reset tw_idx: got %0d want 0", tw_idx); else passes++;
  endtask

  task automatic test_sequence();
    int want_idx[16];
    int got_idx[16];
    int got_re[16];
    int got_im[16];
    int k;
    want_idx = '{0, 0, 0, 0, 0, 2, 4, 6, 0, 1, 2, 3, 0, 3, 6, 9};
    k = 0;
    for (int i = 0; i < 18; i++) begin
      in_valid = (i < 16); in_sync = 1'b0;
      tick();
      checks++;
      if (tw_valid !== exp_v[1]) $display("FAIL seq valid cyc %0d: got %b want %b", i, tw_valid, exp_v[1]);
      else passes++;
      if (exp_v[1] && sb.size() > 0) last = sb.pop_front();
      checks++;
      if (tw_idx !== last.e[3:0] || tw_re !== last.re[15:0] || tw_im !== last.im[15:0])
        $display("FAIL seq data cyc %0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                 i, tw_idx, tw_re, tw_im, last.e, last.re, last.im);
      else passes++;
      if (tw_valid === 1'b1 && k < 16) begin
        got_idx[k] = int'(tw_idx); got_re[k] = int'(tw_re); got_im[k] = int'(tw_im);
        k++;
      end
    end
    checks++; if (k != 16) $display("FAIL seq count: got %0d want 16", k); else passes++;
    for (int i = 0; i < k; i++) begin
      checks++;
      if (got_idx[i] != want_idx[i]) $display("FAIL seq idx[%0d]: got %0d want %0d", i, got_idx[i], want_idx[i]);
      else passes++;
    end
    checks++; if (got_re[0] != 32767 || got_im[0] != 0)
      $display("FAIL tab e0: got (%0d,%0d) want (32767,0)", got_re[0], got_im[0]); else passes++;
    checks++; if (got_re[5] != 23170 || got_im[5] != -23170)
      $display("FAIL tab e2: got (%0d,%0d) want (23170,-23170)", got_re[5], got_im[5]); else passes++;
    checks++; if (got_re[6] != 0 || got_im[6] != -32768)
      $display("FAIL tab e4: got (%0d,%0d) want (0,-32768)", got_re[6], got_im[6]); else passes++;
    checks++; if (got_re[15] != -30274 || got_im[15] != 12540)
      $display("FAIL tab e9: got (%0d,%0d) want (-30274,12540)", got_re[15], got_im[15]); else passes++;
  endtask

  task automatic test_gaps();
    logic pat[8];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      in_valid = pat[i];
      in_sync  = ~pat[i];
      tick();
      checks++;
      if (tw_valid !== exp_v[1]) $display("FAIL gaps valid cyc %0d: got %b want %b", i, tw_valid, exp_v[1]);
      else passes++;
      if (exp_v[1] && sb.size() > 0) last = sb.pop_front();
      checks++;
      if (tw_idx !== last.e[3:0] || tw_re !== last.re[15:0] || tw_im !== last.im[15:0])
        $display("FAIL gaps data cyc %0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                 i, tw_idx, tw_re, tw_im, last.e, last.re, last.im);
      else passes++;
    end
    in_sync = 1'b0;
  endtask

  task automatic test_sync();
    rst = 1'b1; in_valid = 1'b0; in_sync = 1'b0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 28; i++) begin
      in_valid = (i < 26);
      in_sync  = (i == 7);
      tick();
      checks++;
      if (tw_valid !== exp_v[1]) $display("FAIL sync valid cyc %0d: got %b want %b", i, tw_valid, exp_v[1]);
      else passes++;
      if (exp_v[1] && sb.size() > 0) last = sb.pop_front();
      checks++;
      if (tw_idx !== last.e[3:0] || tw_re !== last.re[15:0] || tw_im !== last.im[15:0])
        $display("FAIL sync data cyc %0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                 i, tw_idx, tw_re, tw_im, last.e, last.re, last.im);
      else passes++;
    end
    in_sync = 1'b0;
  endtask

  task automatic test_reset_inflight();
    rst = 1'b0; in_valid = 1'b1; in_sync = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      tick();
      checks++;
      if (tw_valid !== exp_v[1]) $display("FAIL rstfl valid cyc %0d: got %b want %b", i, tw_valid, exp_v[1]);
      else passes++;
      if (exp_v[1] && sb.size() > 0) last = sb.pop_front();
      checks++;
      if (tw_idx !== last.e[3:0] || tw_re !== last.re[15:0] || tw_im !== last.im[15:0])
        $display("FAIL rstfl data cyc %0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                 i, tw_idx, tw_re, tw_im, last.e, last.re, last.im);
      else passes++;
    end
    checks++; if (m_n != 1) $display("FAIL rstfl next index model: got %0d want 1", m_n); else passes++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 200; i++) begin
      in_valid = (i < 196) && ($urandom_range(3) != 0);
      in_sync  = (m_n == N - 1 && i < 60) ? 1'b1 : ($urandom_range(7) == 0);
      tick();
      checks++;
      if (tw_valid !== exp_v[1]) $display("FAIL b2b valid cyc %0d: got %b want %b", i, tw_valid, exp_v[1]);
      else passes++;
      if (exp_v[1] && sb.size() > 0) last = sb.pop_front();
      checks++;
      if (tw_idx !== last.e[3:0] || tw_re !== last.re[15:0] || tw_im !== last.im[15:0])
        $display("FAIL b2b data cyc %0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)",
                 i, tw_idx, tw_re, tw_im, last.e, last.re, last.im);
      else passes++;
    end
    in_valid = 1'b0; in_sync = 1'b0;
    checks++; if (sb.size() != 0) $display("FAIL b2b leftover: got %0d want 0", sb.size()); else passes++;
  endtask

  initial begin
    checks = 0; passes = 0; m_n = 0; exp_v = 2'b00; last = '{0, 0, 0};
    rst = 1'b1; in_valid = 1'b0; in_sync = 1'b0;
    test_reset();
    test_sequence();
    test_gaps();
    test_sync();
    test_reset_inflight();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
